vga_scan_gen: RTL

Raster-scan generator for the 640×480@60 Hz display path. Produces the pixel address stream (`col_addr`/`row_addr`) that the sprite/ROM fetch logic consumes, then accepts the returned 12-bit pixel word a fixed number of pixel ticks later. Drives aligned `hs`, `vs` and RGB to the board connector. It is the consuming end of the pixel-address/pixel-data interface that the game top level answers.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_scan_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, pixel type and colour-bar lookup for the VGA scan path.
package vga_pkg;

    typedef logic [11:0] pixel_t;

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_FP    = 10'd16;
    localparam logic [9:0] H_SYNC  = 10'd96;
    localparam logic [9:0] H_BP    = 10'd48;
    localparam logic [9:0] H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_FP    = 10'd10;
    localparam logic [9:0] V_SYNC  = 10'd2;
    localparam logic [9:0] V_BP    = 10'd33;
    localparam logic [9:0] V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Bar 0 is white, stepping down to bar 7 black.
    function automatic pixel_t bar_colour(input logic [2:0] idx);
        pixel_t c;
        case (idx)
            3'd0:    c = 12'hfff;
            3'd1:    c = 12'hff0;
            3'd2:    c = 12'h0ff;
            3'd3:    c = 12'h0f0;
            3'd4:    c = 12'hf0f;
            3'd5:    c = 12'hf00;
            3'd6:    c = 12'h00f;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Pixel-tick enabled shift register with a synchronous reset value; DEPTH of 0 is a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst ^ pix_ce;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        sr[i] <= RST_VAL;
                    end
                end else if (pix_ce) begin
                    sr[0] <= d;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_gen.sv
// 640x480@60 raster generator: issues pixel addresses, realigns syncs with returned pixel data.
// Optional internal colour bars are built in when VGA_TEST_PATTERN_EN is defined.
module vga_scan_gen #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        test_en,
    input  logic [11:0] d_in,
    output logic [9:0]  col_addr,
    output logic [8:0]  row_addr,
    output logic        rd_req,
    output logic        frame_start,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b
);
    import vga_pkg::*;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       vis;
    logic       hs0;
    logic       vs0;

    assign vis = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // Stage 0 registers describe the position just issued; the counters already point at the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            col_addr    <= '0;
            row_addr    <= '0;
            rd_req      <= 1'b0;
            frame_start <= 1'b0;
            hs0         <= 1'b1;
            vs0         <= 1'b1;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                rd_req      <= vis;
                col_addr    <= vis ? h_cnt : '0;
                row_addr    <= vis ? v_cnt[8:0] : '0;
                hs0         <= !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
                vs0         <= !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                if (h_cnt == H_TOTAL - 10'd1) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    logic   dl_hs;
    logic   dl_vs;
    logic   dl_rd;
    pixel_t pix;

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar0;
    logic [2:0] dl_bar;

    always_ff @(posedge clk) begin
        if (rst) begin
            bar0 <= '0;
        end else if (pix_ce) begin
            bar0 <= h_cnt[9:7];
        end
    end

    vga_delay_line #(
        .WIDTH   (6),
        .DEPTH   (LAT),
        .RST_VAL (6'b110_000)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .d      ({hs0, vs0, rd_req, bar0}),
        .q      ({dl_hs, dl_vs, dl_rd, dl_bar})
    );

    always_comb begin
        pix = d_in;
        if (test_en) begin
            pix = bar_colour(dl_bar);
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LAT),
        .RST_VAL (3'b110)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce),
        .d      ({hs0, vs0, rd_req}),
        .q      ({dl_hs, dl_vs, dl_rd})
    );

    always_comb begin
        pix = d_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hs        <= 1'b1;
            vs        <= 1'b1;
            {r, g, b} <= '0;
        end else if (pix_ce) begin
            hs        <= dl_hs;
            vs        <= dl_vs;
            {r, g, b} <= dl_rd ? pix : '0;
        end
    end

endmodule
